// File: rtl/sd_spi_pkg.sv
// SD-card SPI shifter: shared register map, status bits and FSM encoding.
package sd_spi_pkg;

    localparam logic [1:0] ADDR_DATA   = 2'd0;
    localparam logic [1:0] ADDR_STATUS = 2'd1;
    localparam logic [1:0] ADDR_DIV    = 2'd2;
    localparam logic [1:0] ADDR_CTRL   = 2'd3;

    localparam int ST_BUSY = 0;
    localparam int ST_DONE = 1;
    localparam int ST_OVR  = 2;

    // Keeps the miso synchronizer delay inside one half-period.
    localparam int DIV_MIN = 2;

    typedef enum logic [1:0] {
        IDLE,
        LOW,
        HIGH
    } state_t;

endpackage

// File: rtl/sd_spi_engine.sv
// SPI mode-0 byte engine: divider, bit sequencing, shift register, miso sync.
module sd_spi_engine
    import sd_spi_pkg::*;
#(
    parameter int DIV_W = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [7:0]       tx,
    input  logic [DIV_W-1:0] div,
    input  logic             sd_miso,
    output logic             busy,
    output logic             done_pulse,
    output logic [7:0]       rx,
    output logic             sd_clk,
    output logic             sd_mosi
);

    state_t           state;
    logic [1:0]       sync;
    logic [DIV_W-1:0] hc;
    logic [DIV_W-1:0] d_lat;
    logic [DIV_W-1:0] d_eff;
    logic [2:0]       bc;
    logic [7:0]       sr;

    assign d_eff = (div < DIV_W'(DIV_MIN)) ? DIV_W'(DIV_MIN) : div;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync <= 2'b00;
        end else begin
            sync <= {sync[0], sd_miso};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            sd_clk     <= 1'b0;
            sd_mosi    <= 1'b1;
            busy       <= 1'b0;
            done_pulse <= 1'b0;
            rx         <= 8'h00;
            sr         <= 8'h00;
            hc         <= '0;
            d_lat      <= DIV_W'(DIV_MIN);
            bc         <= 3'd0;
        end else begin
            done_pulse <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        sr      <= tx;
                        sd_mosi <= tx[7];
                        hc      <= d_eff;
                        d_lat   <= d_eff;
                        bc      <= 3'd0;
                        busy    <= 1'b1;
                        state   <= LOW;
                    end
                end
                LOW: begin
                    if (hc == '0) begin
                        sd_clk <= 1'b1;
                        sr     <= {sr[6:0], sync[1]};
                        hc     <= d_lat;
                        state  <= HIGH;
                    end else begin
                        hc <= hc - 1'b1;
                    end
                end
                HIGH: begin
                    if (hc == '0) begin
                        sd_clk <= 1'b0;
                        if (bc == 3'd7) begin
                            rx         <= sr;
                            busy       <= 1'b0;
                            done_pulse <= 1'b1;
                            sd_mosi    <= 1'b1;
                            state      <= IDLE;
                        end else begin
                            bc      <= bc + 3'd1;
                            sd_mosi <= sr[7];
                            hc      <= d_lat;
                            state   <= LOW;
                        end
                    end else begin
                        hc <= hc - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: rtl/sd_spi_shifter.sv
// Avalon-MM front end for the SD SPI engine: register file and read mux.
module sd_spi_shifter
    import sd_spi_pkg::*;
#(
    parameter int DIV_W     = 16,
    parameter int DIV_RESET = 124
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [1:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic        read_n,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        sd_clk,
    output logic        sd_mosi,
    output logic        sd_cs_n,
    input  logic        sd_miso
);

    logic             wr_en;
    logic             rd_en;
    logic             start;
    logic             busy;
    logic             done_pulse;
    logic             done;
    logic             ovr;
    logic             cs_q;
    logic [7:0]       rx;
    logic [DIV_W-1:0] div;
    logic             unused;

    assign wr_en  = chipselect && !write_n;
    assign rd_en  = chipselect && !read_n;
    assign start  = wr_en && (address == ADDR_DATA) && !busy;
    assign unused = ^writedata[31:DIV_W];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            done <= 1'b0;
            ovr  <= 1'b0;
            div  <= DIV_W'(DIV_RESET);
            cs_q <= 1'b1;
        end else begin
            if (done_pulse) begin
                done <= 1'b1;
            end else if (start || (rd_en && address == ADDR_DATA)) begin
                done <= 1'b0;
            end
            // A DATA write that lands while busy is dropped, not queued.
            if (wr_en && address == ADDR_DATA && busy) begin
                ovr <= 1'b1;
            end else if (wr_en && address == ADDR_STATUS && writedata[ST_OVR]) begin
                ovr <= 1'b0;
            end
            if (wr_en && address == ADDR_DIV) begin
                div <= writedata[DIV_W-1:0];
            end
            if (wr_en && address == ADDR_CTRL) begin
                cs_q <= writedata[0];
            end
        end
    end

    assign sd_cs_n = cs_q;

    sd_spi_engine #(
        .DIV_W (DIV_W)
    ) u_engine (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .tx         (writedata[7:0]),
        .div        (div),
        .sd_miso    (sd_miso),
        .busy       (busy),
        .done_pulse (done_pulse),
        .rx         (rx),
        .sd_clk     (sd_clk),
        .sd_mosi    (sd_mosi)
    );

    always_comb begin
        readdata = 32'h0;
        unique case (1'b1)
            (address == ADDR_DATA):   readdata = {24'h0, rx};
            (address == ADDR_STATUS): readdata = {29'h0, ovr, done, busy};
            (address == ADDR_DIV):    readdata = {{(32-DIV_W){1'b0}}, div};
            (address == ADDR_CTRL):   readdata = {31'h0, cs_q};
            default:                  readdata = 32'h0;
        endcase
    end

endmodule
